// File: rtl/lift_pkg.sv
// Shared types for the N-floor lift: state encoding, direction constants
// and the call-search helpers used by the SCAN scheduler.
package lift_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      MOVE_UP      = 3'd1,
      MOVE_DOWN    = 3'd2,
      DOOR_OPENING = 3'd3,
      DOOR_OPEN    = 3'd4,
      DOOR_CLOSING = 3'd5
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int MAX_FLOORS = 64;

   // Callers zero-extend their call vector and floor index to the widest build.
   function automatic logic any_above(input logic [MAX_FLOORS-1:0] pending,
                                      input logic [5:0] cur_floor);
      logic found;
      found = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (pending[i] && (i > int'(cur_floor))) found = 1'b1;
      return found;
   endfunction

   function automatic logic any_below(input logic [MAX_FLOORS-1:0] pending,
                                      input logic [5:0] cur_floor);
      logic found;
      found = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (pending[i] && (i < int'(cur_floor))) found = 1'b1;
      return found;
   endfunction

endpackage

// File: rtl/lift_controller_nfloor_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module lift_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/lift_controller_nfloor.sv
// N-floor lift controller with latched calls and SCAN scheduling.
// Define FIRE_RECALL_EN to add the in_fire_recall input and recall-to-floor-0 behaviour.
module lift_controller_nfloor
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS    = 11,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 8,
   parameter int DWELL_CYCLES  = 32,
   parameter int FLW           = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef FIRE_RECALL_EN
   input  logic                  in_fire_recall,
`endif
   input  logic [NUM_FLOORS-1:0] in_call,
   input  logic                  in_door_obstacle,
   input  logic                  in_door_open,
   input  logic                  in_door_close,
   output logic                  out_up_direction,
   output logic                  out_down_direction,
   output logic                  out_door_opening,
   output logic                  out_door_closing,
   output logic                  out_ready,
   output logic [FLW-1:0]        out_floor,
   output logic [NUM_FLOORS-1:0] out_pending
);

   localparam int TW   = $clog2(TRAVEL_CYCLES + 1);
   localparam int DMAX = (DWELL_CYCLES > DOOR_CYCLES) ? DWELL_CYCLES : DOOR_CYCLES;
   localparam int DW   = $clog2(DMAX + 1);
   localparam logic [FLW-1:0] TOP_FLOOR = FLW'(NUM_FLOORS - 1);

   state_t                  state, state_nxt;
   logic [FLW-1:0]          floor, floor_nxt;
   logic                    dir, dir_nxt;
   logic [NUM_FLOORS-1:0]   pending, pending_nxt;
   logic [NUM_FLOORS-1:0]   calls_raw, calls, here_mask;
   logic                    recall, dwell_reload;
   logic                    travel_load, travel_done, door_load, door_done;
   logic [DW-1:0]           door_value;

`ifdef FIRE_RECALL_EN
   assign recall = in_fire_recall;
`else
   assign recall = 1'b0;
`endif

   // A call for the floor whose door is opening or open is served on the spot.
   assign here_mask = NUM_FLOORS'(1) << floor;
   assign calls_raw = recall ? '0 : (pending | in_call);
   assign calls     = (state == DOOR_OPENING || state == DOOR_OPEN) ?
                      (calls_raw & ~here_mask) : calls_raw;

   assign travel_load = !((state == MOVE_UP || state == MOVE_DOWN) && !travel_done);

   always_comb begin
      state_nxt    = state;
      floor_nxt    = floor;
      dir_nxt      = dir;
      dwell_reload = 1'b0;
      case (state)
         IDLE: begin
            if (recall) begin
               if (floor == '0) state_nxt = DOOR_OPENING;
               else begin
                  state_nxt = MOVE_DOWN;
                  dir_nxt   = DIR_DOWN;
               end
            end else if (calls[floor] || in_door_open)
               state_nxt = DOOR_OPENING;
            else if (dir == DIR_UP && any_above(64'(calls), 6'(floor)))
               state_nxt = MOVE_UP;
            else if (any_below(64'(calls), 6'(floor))) begin
               state_nxt = MOVE_DOWN;
               dir_nxt   = DIR_DOWN;
            end else if (any_above(64'(calls), 6'(floor))) begin
               state_nxt = MOVE_UP;
               dir_nxt   = DIR_UP;
            end
         end
         MOVE_UP: if (travel_done) begin
            floor_nxt = (floor == TOP_FLOOR) ? floor : floor + 1'b1;
            if (recall) begin
               state_nxt = MOVE_DOWN;
               dir_nxt   = DIR_DOWN;
            end else if (calls[floor_nxt])
               state_nxt = DOOR_OPENING;
            else if (!any_above(64'(calls), 6'(floor_nxt)))
               state_nxt = IDLE;
         end
         MOVE_DOWN: if (travel_done) begin
            floor_nxt = (floor == '0) ? floor : floor - 1'b1;
            if (recall)
               state_nxt = (floor_nxt == '0) ? DOOR_OPENING : MOVE_DOWN;
            else if (calls[floor_nxt])
               state_nxt = DOOR_OPENING;
            else if (!any_below(64'(calls), 6'(floor_nxt)))
               state_nxt = IDLE;
         end
         DOOR_OPENING: if (door_done) state_nxt = DOOR_OPEN;
         DOOR_OPEN: begin
            // Holding the door at the recall floor is a dwell reload every cycle.
            if (in_door_open || in_door_obstacle || (in_call[floor] && !recall) ||
                (recall && floor == '0))
               dwell_reload = 1'b1;
            else if (recall || in_door_close || door_done)
               state_nxt = DOOR_CLOSING;
         end
         DOOR_CLOSING: begin
            if (in_door_obstacle || in_door_open) state_nxt = DOOR_OPENING;
            else if (door_done)                   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      pending_nxt = calls;
      if (state_nxt == DOOR_OPENING)
         pending_nxt = calls & ~(NUM_FLOORS'(1) << floor_nxt);

      door_load  = (state_nxt != state) || dwell_reload;
      door_value = (state_nxt == DOOR_OPEN) ? DW'(DWELL_CYCLES - 1) : DW'(DOOR_CYCLES - 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         floor   <= '0;
         dir     <= DIR_UP;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         floor   <= floor_nxt;
         dir     <= dir_nxt;
         pending <= pending_nxt;
      end
   end

   lift_timer #(.W(TW)) u_travel_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (travel_load),
      .value (TW'(TRAVEL_CYCLES - 1)),
      .done  (travel_done)
   );

   lift_timer #(.W(DW)) u_door_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (door_load),
      .value (door_value),
      .done  (door_done)
   );

   assign out_up_direction   = (state == MOVE_UP);
   assign out_down_direction = (state == MOVE_DOWN);
   assign out_door_opening   = (state == DOOR_OPENING);
   assign out_door_closing   = (state == DOOR_CLOSING);
   assign out_ready          = (state == IDLE);
   assign out_floor          = floor;
   assign out_pending        = pending;

endmodule

// File: tb/tb_lift_controller_nfloor.sv
// Directed bench for lift_controller_nfloor (8 floors, travel 4, door 2, dwell 6).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_lift_controller_nfloor;

   localparam logic [4:0] ST_IDLE = 5'b00001;
   localparam logic [4:0] ST_UP   = 5'b10000;
   localparam logic [4:0] ST_DN   = 5'b01000;
   localparam logic [4:0] ST_OPN  = 5'b00100;
   localparam logic [4:0] ST_OPEN = 5'b00000;
   localparam logic [4:0] ST_CLS  = 5'b00010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_call;
   logic       in_door_obstacle, in_door_open, in_door_close;
`ifdef FIRE_RECALL_EN
   logic       in_fire_recall;
`endif
   logic       out_up_direction, out_down_direction, out_door_opening, out_door_closing;
   logic       out_ready;
   logic [2:0] out_floor;
   logic [7:0] out_pending;
   logic [7:0] obs_vec;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   lift_controller_nfloor #(
      .NUM_FLOORS    (8),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (2),
      .DWELL_CYCLES  (6)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
`ifdef FIRE_RECALL_EN
      .in_fire_recall     (in_fire_recall),
`endif
      .in_call            (in_call),
      .in_door_obstacle   (in_door_obstacle),
      .in_door_open       (in_door_open),
      .in_door_close      (in_door_close),
      .out_up_direction   (out_up_direction),
      .out_down_direction (out_down_direction),
      .out_door_opening   (out_door_opening),
      .out_door_closing   (out_door_closing),
      .out_ready          (out_ready),
      .out_floor          (out_floor),
      .out_pending        (out_pending)
   );

   assign obs_vec = {out_up_direction, out_down_direction, out_door_opening,
                     out_door_closing, out_ready, out_floor};

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic checkNow(input string tag, input logic [4:0] st, input logic [2:0] fl,
                           input logic [7:0] pend);
      checkOutput({tag, " state"}, obs_vec, {st, fl});
      checkOutput({tag, " pend"}, out_pending, pend);
   endtask

   task automatic expectRun(input string tag, input logic [4:0] st, input logic [2:0] fl,
                            input logic [7:0] pend, input int n);
      for (int i = 0; i < n; i++) begin
         checkNow(tag, st, fl, pend);
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] call, input logic obst,
                                input logic open_b, input logic close_b);
      in_call          = call;
      in_door_obstacle = obst;
      in_door_open     = open_b;
      in_door_close    = close_b;
   endtask

   task automatic pulseCall(input logic [7:0] call);
      applyStimulus(call, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
`ifdef FIRE_RECALL_EN
      in_fire_recall = 1'b0;
`endif
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkNow("reset", ST_IDLE, 3'd0, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      checkNow("idle after reset", ST_IDLE, 3'd0, 8'h00);

      $display("[TB] call 3 from floor 0");
      pulseCall(8'h08);
      expectRun("t1 up f0", ST_UP, 3'd0, 8'h08, 4);
      expectRun("t1 up f1", ST_UP, 3'd1, 8'h08, 4);
      expectRun("t1 up f2", ST_UP, 3'd2, 8'h08, 4);
      expectRun("t1 opening", ST_OPN, 3'd3, 8'h00, 2);
      expectRun("t1 open", ST_OPEN, 3'd3, 8'h00, 6);
      expectRun("t1 closing", ST_CLS, 3'd3, 8'h00, 2);
      checkNow("t1 idle", ST_IDLE, 3'd3, 8'h00);

      $display("[TB] call 4 from floor 3");
      pulseCall(8'h10);
      expectRun("t2 up f3", ST_UP, 3'd3, 8'h10, 4);
      expectRun("t2 opening", ST_OPN, 3'd4, 8'h00, 2);
      expectRun("t2 open", ST_OPEN, 3'd4, 8'h00, 6);
      expectRun("t2 closing", ST_CLS, 3'd4, 8'h00, 2);
      checkNow("t2 idle", ST_IDLE, 3'd4, 8'h00);

      $display("[TB] call at own floor, then obstacle while closing");
      pulseCall(8'h10);
      expectRun("t3 opening", ST_OPN, 3'd4, 8'h00, 2);
      expectRun("t3 open", ST_OPEN, 3'd4, 8'h00, 6);
      expectRun("t3 closing 1st", ST_CLS, 3'd4, 8'h00, 1);
      checkNow("t3 closing 2nd", ST_CLS, 3'd4, 8'h00);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      expectRun("t3 reopening", ST_OPN, 3'd4, 8'h00, 2);
      expectRun("t3 dwell again", ST_OPEN, 3'd4, 8'h00, 6);
      expectRun("t3 closing", ST_CLS, 3'd4, 8'h00, 2);
      checkNow("t3 idle", ST_IDLE, 3'd4, 8'h00);

      $display("[TB] asynchronous reset mid-travel");
      pulseCall(8'h01);
      expectRun("t4 down f4", ST_DN, 3'd4, 8'h01, 4);
      checkNow("t4 down f3", ST_DN, 3'd3, 8'h01);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkNow("t4 async reset", ST_IDLE, 3'd0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      checkNow("t4 post reset", ST_IDLE, 3'd0, 8'h00);

      $display("[TB] call 5, then call 1 while passing floor 2");
      pulseCall(8'h20);
      expectRun("t5 up f0", ST_UP, 3'd0, 8'h20, 4);
      expectRun("t5 up f1", ST_UP, 3'd1, 8'h20, 4);
      checkNow("t5 up f2", ST_UP, 3'd2, 8'h20);
      pulseCall(8'h02);
      expectRun("t5 up f2 late", ST_UP, 3'd2, 8'h22, 3);
      expectRun("t5 up f3", ST_UP, 3'd3, 8'h22, 4);
      expectRun("t5 up f4", ST_UP, 3'd4, 8'h22, 4);
      expectRun("t5 opening f5", ST_OPN, 3'd5, 8'h02, 2);
      expectRun("t5 open f5", ST_OPEN, 3'd5, 8'h02, 6);
      expectRun("t5 closing f5", ST_CLS, 3'd5, 8'h02, 2);
      expectRun("t5 idle f5", ST_IDLE, 3'd5, 8'h02, 1);
      expectRun("t5 down f5", ST_DN, 3'd5, 8'h02, 4);
      expectRun("t5 down f4", ST_DN, 3'd4, 8'h02, 4);
      expectRun("t5 down f3", ST_DN, 3'd3, 8'h02, 4);
      expectRun("t5 down f2", ST_DN, 3'd2, 8'h02, 4);
      expectRun("t5 opening f1", ST_OPN, 3'd1, 8'h00, 2);
      expectRun("t5 open f1", ST_OPEN, 3'd1, 8'h00, 6);
      expectRun("t5 closing f1", ST_CLS, 3'd1, 8'h00, 2);
      checkNow("t5 idle f1", ST_IDLE, 3'd1, 8'h00);

      $display("[TB] door buttons");
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      expectRun("t6 opening", ST_OPN, 3'd1, 8'h00, 2);
      checkNow("t6 open", ST_OPEN, 3'd1, 8'h00);
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      checkNow("t6 open wins", ST_OPEN, 3'd1, 8'h00);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      expectRun("t6 close button", ST_CLS, 3'd1, 8'h00, 2);
      checkNow("t6 idle", ST_IDLE, 3'd1, 8'h00);

`ifdef FIRE_RECALL_EN
      $display("[TB] fire recall while travelling up");
      pulseCall(8'h80);
      expectRun("t7 up f1", ST_UP, 3'd1, 8'h80, 4);
      expectRun("t7 up f2", ST_UP, 3'd2, 8'h80, 4);
      expectRun("t7 up f3", ST_UP, 3'd3, 8'h80, 4);
      expectRun("t7 up f4", ST_UP, 3'd4, 8'h80, 4);
      checkNow("t7 up f5", ST_UP, 3'd5, 8'h80);
      in_fire_recall = 1'b1;
      @(negedge clk);
      expectRun("t7 up f5 recall", ST_UP, 3'd5, 8'h00, 3);
      for (int f = 6; f >= 1; f--)
         expectRun("t7 recall down", ST_DN, 3'(f), 8'h00, 4);
      expectRun("t7 opening f0", ST_OPN, 3'd0, 8'h00, 2);
      expectRun("t7 held open", ST_OPEN, 3'd0, 8'h00, 20);
      in_fire_recall = 1'b0;
      expectRun("t7 dwell", ST_OPEN, 3'd0, 8'h00, 6);
      expectRun("t7 closing", ST_CLS, 3'd0, 8'h00, 2);
      checkNow("t7 idle", ST_IDLE, 3'd0, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
